// File: rtl/hi_init_sequencer_if.sv
// hi_init_sequencer_if: HI write-port bundle between an init-sequencer host and the arbitor
interface hi_init_sequencer_if;
    logic        lock_arbitor;
    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic [31:0] di_len;
    logic        di_write_mode;
    logic        di_write;
    logic [31:0] di_reg_datai;
    logic        di_write_rdy;
    logic        di_read_mode;
    logic        di_read_req;
    logic        di_read;
    modport master (
        output lock_arbitor, di_term_addr, di_reg_addr, di_len, di_write_mode, di_write,
               di_reg_datai, di_read_mode, di_read_req, di_read,
        input  di_write_rdy
    );
    modport slave (
        input  lock_arbitor, di_term_addr, di_reg_addr, di_len, di_write_mode, di_write,
               di_reg_datai, di_read_mode, di_read_req, di_read,
        output di_write_rdy
    );
endinterface

// File: rtl/hi_init_sequencer.sv
// hi_init_sequencer: walks a register-write table and issues each entry as a single-word HI write
module hi_init_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 65535,
    parameter bit LOCK    = 1'b1
) (
    input  logic              ifclk,
    input  logic              resetb,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_idx,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [15:0]       tbl_term,
    input  logic [31:0]       tbl_reg,
    input  logic [31:0]       tbl_data,
    hi_init_sequencer_if.master hi
);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, WAIT, GAP, DELAY, DONE, ERROR} state_t;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt, err_idx_nxt;
    logic [TW-1:0] tmo, tmo_nxt;
    logic [31:0] cnt, cnt_nxt, reg_q, reg_nxt, data_q, data_nxt;
    logic [15:0] term_q, term_nxt;
    logic locked, locked_nxt, error_nxt, last;
    assign last = &idx;
    assign tbl_addr = idx;
    assign busy = state inside {FETCH, DECODE, WAIT, GAP, DELAY};
    assign done = state == DONE;
    assign hi.lock_arbitor = LOCK && locked && busy;
    assign hi.di_term_addr = term_q;
    assign hi.di_reg_addr = reg_q;
    assign hi.di_reg_datai = data_q;
    assign hi.di_len = 32'd4;
    assign hi.di_write_mode = state == WAIT;
    assign hi.di_write = state == WAIT && hi.di_write_rdy;
    assign hi.di_read_mode = 1'b0;
    assign hi.di_read_req = 1'b0;
    assign hi.di_read = 1'b0;
    always_comb begin
        state_nxt = state;
        idx_nxt = idx;
        tmo_nxt = tmo;
        cnt_nxt = cnt;
        locked_nxt = locked;
        error_nxt = error;
        err_idx_nxt = err_idx;
        term_nxt = term_q;
        reg_nxt = reg_q;
        data_nxt = data_q;
        case (state)
            IDLE, DONE, ERROR: begin
                state_nxt = start ? FETCH : (state == ERROR ? ERROR : IDLE);
                idx_nxt = start ? '0 : idx;
                error_nxt = error && !start;
                locked_nxt = locked && !start;
            end
            FETCH: state_nxt = DECODE;
            DECODE: begin
                state_nxt = tbl_term == 16'hFFFF ? DONE : (tbl_term == 16'hFFFE ? DELAY : WAIT);
                cnt_nxt = tbl_data;
                if (state_nxt == WAIT) begin
                    tmo_nxt = '0;
                    locked_nxt = 1'b1;
                    term_nxt = tbl_term;
                    reg_nxt = tbl_reg;
                    data_nxt = tbl_data;
                end
            end
            WAIT: begin
                if (hi.di_write_rdy) state_nxt = GAP;
                else if (tmo == TW'(TIMEOUT)) begin
                    state_nxt = ERROR;
                    error_nxt = 1'b1;
                    err_idx_nxt = idx;
                end else tmo_nxt = tmo + 1'b1;
            end
            // the last table slot finishes the sequence rather than wrapping to index 0
            GAP, DELAY: begin
                if (state == GAP || cnt == 32'd0) begin
                    state_nxt = last ? DONE : FETCH;
                    idx_nxt = idx + ADDR_W'(!last);
                end else cnt_nxt = cnt - 32'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
            idx <= '0;
            tmo <= '0;
            cnt <= '0;
            locked <= 1'b0;
            error <= 1'b0;
            err_idx <= '0;
            term_q <= '0;
            reg_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            idx <= idx_nxt;
            tmo <= tmo_nxt;
            cnt <= cnt_nxt;
            locked <= locked_nxt;
            error <= error_nxt;
            err_idx <= err_idx_nxt;
            term_q <= term_nxt;
            reg_q <= reg_nxt;
            data_q <= data_nxt;
        end
    end
endmodule
